// File: rtl/axi_rr_master_arbiter.sv
// AXI4 master-side arbiter: AW/AR grant selection, W grant-order FIFO,
// and ID-based B/R routing for the shared bus muxes.

module axi_arb_chan_stage #(
   parameter int M_NUM    = 4,
   parameter int M_WIDTH  = 2,
   parameter int ARB_MODE = 1
) (
   input  logic               clk,
   input  logic               rst,
   input  logic [M_NUM-1:0]   req,
   input  logic               block,
   input  logic               bus_valid,
   input  logic               bus_ready,
   output logic [M_WIDTH-1:0] sel,
   output logic               sel_valid
);

   typedef enum logic {
      ST_OPEN,
      ST_LOCK
   } state_t;

   state_t             state;
   logic [M_WIDTH-1:0] sel_q;
   logic [M_WIDTH-1:0] last_q;
   logic [M_WIDTH-1:0] winner;
   logic [M_WIDTH-1:0] idx_w;
   int                 idx;
   logic               any_req;
   logic               locked;
   logic               hs;

   assign any_req = |req;
   assign locked  = (state == ST_LOCK);

   // Scan from farthest to nearest so the nearest requester overwrites
   always_comb begin
      winner = sel_q;
      idx    = 0;
      idx_w  = '0;
      if (ARB_MODE == 0) begin
         for (int i = M_NUM - 1; i >= 0; i--) begin
            idx_w = M_WIDTH'(i);
            if (req[idx_w])
               winner = idx_w;
         end
      end else begin
         for (int i = M_NUM; i >= 1; i--) begin
            idx = int'(last_q) + i;
            if (idx >= M_NUM)
               idx = idx - M_NUM;
            idx_w = M_WIDTH'(idx);
            if (req[idx_w])
               winner = idx_w;
         end
      end
   end

   always_comb begin
      sel = sel_q;
      if (rst)
         sel = '0;
      else if (!locked && any_req)
         sel = winner;
   end

   assign sel_valid = !rst && (any_req || locked) && !block;
   assign hs        = sel_valid && bus_valid && bus_ready;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state  <= ST_OPEN;
         sel_q  <= '0;
         last_q <= M_WIDTH'(M_NUM - 1);
      end else begin
         sel_q <= sel;
         if (hs) begin
            state  <= ST_OPEN;
            last_q <= sel;
         end else if (sel_valid && bus_valid) begin
            state <= ST_LOCK;
         end
      end
   end

endmodule

module axi_wr_order_fifo_stage #(
   parameter int DEPTH = 4,
   parameter int W     = 2
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         push,
   input  logic [W-1:0] push_data,
   input  logic         pop,
   output logic [W-1:0] head,
   output logic         empty,
   output logic         full
);

   localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   logic [W-1:0]  mem [DEPTH];
   logic [PW-1:0] wr_ptr;
   logic [PW-1:0] rd_ptr;
   logic [PW:0]   count;

   assign full  = (count == (PW+1)'(DEPTH));
   assign empty = (count == '0);
   assign head  = mem[rd_ptr];

   // Pointers wrap naturally because DEPTH is a power of two
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
         for (int i = 0; i < DEPTH; i++)
            mem[i] <= '0;
      end else begin
         if (push) begin
            mem[wr_ptr] <= push_data;
            wr_ptr      <= wr_ptr + 1'b1;
         end
         if (pop)
            rd_ptr <= rd_ptr + 1'b1;
         unique case ({push, pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

endmodule

module axi_rr_master_arbiter #(
   parameter int M_NUM         = 4,
   parameter int M_WIDTH       = (M_NUM > 1) ? $clog2(M_NUM) : 1,
   parameter int M_ID          = 2,
   parameter int ARB_MODE      = 1,
   parameter int WR_FIFO_DEPTH = 4
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic [M_NUM-1:0]        MASTER_WR_ADDR_VALID,
   input  logic [M_NUM-1:0]        MASTER_RD_ADDR_VALID,
   input  logic                    BUS_WR_ADDR_VALID,
   input  logic                    BUS_WR_ADDR_READY,
   input  logic                    BUS_WR_DATA_VALID,
   input  logic                    BUS_WR_DATA_READY,
   input  logic                    BUS_WR_DATA_LAST,
   input  logic [M_ID+M_WIDTH-1:0] BUS_WR_BACK_ID,
   input  logic                    BUS_RD_ADDR_VALID,
   input  logic                    BUS_RD_ADDR_READY,
   input  logic [M_ID+M_WIDTH-1:0] BUS_RD_BACK_ID,
   output logic [M_WIDTH-1:0]      wr_addr_master_sel,
   output logic                    wr_addr_sel_valid,
   output logic [M_WIDTH-1:0]      wr_data_master_sel,
   output logic                    wr_data_sel_valid,
   output logic [M_WIDTH-1:0]      wr_resp_master_sel,
   output logic [M_WIDTH-1:0]      rd_addr_master_sel,
   output logic                    rd_addr_sel_valid,
   output logic [M_WIDTH-1:0]      rd_data_master_sel
);

   logic fifo_full;
   logic fifo_empty;
   logic aw_push;
   logic w_pop;

   axi_arb_chan_stage #(
      .M_NUM    (M_NUM),
      .M_WIDTH  (M_WIDTH),
      .ARB_MODE (ARB_MODE)
   ) u_aw (
      .clk       (clk),
      .rst       (rst),
      .req       (MASTER_WR_ADDR_VALID),
      .block     (fifo_full),
      .bus_valid (BUS_WR_ADDR_VALID),
      .bus_ready (BUS_WR_ADDR_READY),
      .sel       (wr_addr_master_sel),
      .sel_valid (wr_addr_sel_valid)
   );

   axi_arb_chan_stage #(
      .M_NUM    (M_NUM),
      .M_WIDTH  (M_WIDTH),
      .ARB_MODE (ARB_MODE)
   ) u_ar (
      .clk       (clk),
      .rst       (rst),
      .req       (MASTER_RD_ADDR_VALID),
      .block     (1'b0),
      .bus_valid (BUS_RD_ADDR_VALID),
      .bus_ready (BUS_RD_ADDR_READY),
      .sel       (rd_addr_master_sel),
      .sel_valid (rd_addr_sel_valid)
   );

   assign aw_push = wr_addr_sel_valid && BUS_WR_ADDR_VALID
                 && BUS_WR_ADDR_READY;
   assign w_pop   = !fifo_empty && BUS_WR_DATA_VALID
                 && BUS_WR_DATA_READY && BUS_WR_DATA_LAST;

   axi_wr_order_fifo_stage #(
      .DEPTH (WR_FIFO_DEPTH),
      .W     (M_WIDTH)
   ) u_wfifo (
      .clk       (clk),
      .rst       (rst),
      .push      (aw_push),
      .push_data (wr_addr_master_sel),
      .pop       (w_pop),
      .head      (wr_data_master_sel),
      .empty     (fifo_empty),
      .full      (fifo_full)
   );

   assign wr_data_sel_valid  = !fifo_empty;
   assign wr_resp_master_sel = BUS_WR_BACK_ID[M_ID +: M_WIDTH];
   assign rd_data_master_sel = BUS_RD_BACK_ID[M_ID +: M_WIDTH];

endmodule

// File: tb/tb_axi_rr_master_arbiter.sv
// Directed bench for axi_rr_master_arbiter: three instances
// (4-master RR, 4-master fixed priority, 3-master RR).

module tb_axi_rr_master_arbiter;

   logic       clk = 1'b0;
   logic       rst;
   logic [3:0] awv;
   logic [3:0] arv;
   logic       bus_awv, bus_awr;
   logic       bus_wv, bus_wr, bus_wl;
   logic       bus_arv, bus_arr;
   logic [3:0] bid, rid;

   logic [1:0] aw_sel [3];
   logic       aw_ok  [3];
   logic [1:0] w_sel  [3];
   logic       w_ok   [3];
   logic [1:0] b_sel  [3];
   logic [1:0] ar_sel [3];
   logic       ar_ok  [3];
   logic [1:0] r_sel  [3];

   int tests = 0;
   int fails = 0;

   always #5 clk = ~clk;

   // g=0: 4-master RR, g=1: 4-master fixed, g=2: 3-master RR
   for (genvar g = 0; g < 3; g++) begin : g_dut
      localparam int MN = (g == 2) ? 3 : 4;
      axi_rr_master_arbiter #(
         .M_NUM    (MN),
         .ARB_MODE ((g == 1) ? 0 : 1)
      ) u_dut (
         .clk                  (clk),
         .rst                  (rst),
         .MASTER_WR_ADDR_VALID (awv[MN-1:0]),
         .MASTER_RD_ADDR_VALID (arv[MN-1:0]),
         .BUS_WR_ADDR_VALID    (bus_awv),
         .BUS_WR_ADDR_READY    (bus_awr),
         .BUS_WR_DATA_VALID    (bus_wv),
         .BUS_WR_DATA_READY    (bus_wr),
         .BUS_WR_DATA_LAST     (bus_wl),
         .BUS_WR_BACK_ID       (bid),
         .BUS_RD_ADDR_VALID    (bus_arv),
         .BUS_RD_ADDR_READY    (bus_arr),
         .BUS_RD_BACK_ID       (rid),
         .wr_addr_master_sel   (aw_sel[g]),
         .wr_addr_sel_valid    (aw_ok[g]),
         .wr_data_master_sel   (w_sel[g]),
         .wr_data_sel_valid    (w_ok[g]),
         .wr_resp_master_sel   (b_sel[g]),
         .rd_addr_master_sel   (ar_sel[g]),
         .rd_addr_sel_valid    (ar_ok[g]),
         .rd_data_master_sel   (r_sel[g])
      );
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      awv = '0; arv = '0;
      bus_awv = 0; bus_awr = 0;
      bus_wv = 0; bus_wr = 0; bus_wl = 0;
      bus_arv = 0; bus_arr = 0;
      bid = '0; rid = '0;
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      awv = '0; arv = '0;
      bus_awv = 0; bus_awr = 0;
      bus_wv = 0; bus_wr = 0; bus_wl = 0;
      bus_arv = 0; bus_arr = 0;
      bid = '0; rid = '0;
      #2;
      for (int g = 0; g < 3; g++) begin
         tests++;
         if ({aw_sel[g], aw_ok[g], w_sel[g], w_ok[g], ar_sel[g], ar_ok[g]}
             !== 9'b0) begin
            fails++;
            $display("FAIL reset g=%0d got aw=%0d/%0b w=%0d/%0b ar=%0d/%0b want all 0",
                     g, aw_sel[g], aw_ok[g], w_sel[g], w_ok[g], ar_sel[g], ar_ok[g]);
         end
      end
      do_reset();
   endtask

   task automatic test_rr_fairness();
      logic [1:0] exp3;
      do_reset();
      awv = 4'b0111;
      bus_awv = 1; bus_awr = 1;
      bus_wv = 1; bus_wr = 1; bus_wl = 1;
      for (int k = 0; k < 6; k++) begin
         exp3 = 2'(k % 3);
         @(negedge clk);
         tests++;
         if (aw_sel[2] !== exp3 || aw_ok[2] !== 1'b1) begin
            fails++;
            $display("FAIL rr3_aw k=%0d got %0d/%0b want %0d/1",
                     k, aw_sel[2], aw_ok[2], exp3);
         end
         tick();
      end
   endtask

   task automatic test_ar_rr_lock();
      logic [1:0] exp_ar [4];
      exp_ar = '{2'd1, 2'd3, 2'd1, 2'd3};
      do_reset();
      arv = 4'b1010;
      bus_arv = 1; bus_arr = 1;
      for (int k = 0; k < 4; k++) begin
         @(negedge clk);
         tests++;
         if (ar_sel[0] !== exp_ar[k] || ar_ok[0] !== 1'b1) begin
            fails++;
            $display("FAIL ar_rr k=%0d got %0d/%0b want %0d/1",
                     k, ar_sel[0], ar_ok[0], exp_ar[k]);
         end
         tick();
      end
      arv = 4'b0001; bus_arr = 0;
      tick();
      arv = 4'b1000;
      @(negedge clk);
      tests++;
      if (ar_sel[0] !== 2'd0 || ar_ok[0] !== 1'b1) begin
         fails++;
         $display("FAIL ar_lock got %0d/%0b want 0/1", ar_sel[0], ar_ok[0]);
      end
      tick();
      arv = 4'b0000; bus_arr = 1;
      tick();
      @(negedge clk);
      tests++;
      if (ar_ok[0] !== 1'b0) begin
         fails++;
         $display("FAIL ar_idle got %0b want 0", ar_ok[0]);
      end
      tick();
   endtask

   task automatic test_fixed_priority();
      logic [1:0] exp_fp [5];
      logic [3:0] req_fp [5];
      exp_fp = '{2'd1, 2'd1, 2'd1, 2'd2, 2'd1};
      req_fp = '{4'b0110, 4'b0110, 4'b0110, 4'b0100, 4'b0110};
      do_reset();
      bus_awv = 1; bus_awr = 1;
      bus_wv = 1; bus_wr = 1; bus_wl = 1;
      for (int k = 0; k < 5; k++) begin
         awv = req_fp[k];
         @(negedge clk);
         tests++;
         if (aw_sel[1] !== exp_fp[k] || aw_ok[1] !== 1'b1) begin
            fails++;
            $display("FAIL fixed_aw k=%0d got %0d/%0b want %0d/1",
                     k, aw_sel[1], aw_ok[1], exp_fp[k]);
         end
         tick();
      end
   endtask

   task automatic test_lock();
      do_reset();
      awv = 4'b0100;
      bus_awv = 1; bus_awr = 0;
      @(negedge clk);
      tests++;
      if (aw_sel[0] !== 2'd2 || aw_ok[0] !== 1'b1) begin
         fails++;
         $display("FAIL lock_first got %0d/%0b want 2/1", aw_sel[0], aw_ok[0]);
      end
      tick();
      awv = 4'b0101;
      for (int k = 0; k < 4; k++) begin
         @(negedge clk);
         tests++;
         if (aw_sel[0] !== 2'd2 || aw_ok[0] !== 1'b1) begin
            fails++;
            $display("FAIL lock_hold k=%0d got %0d/%0b want 2/1",
                     k, aw_sel[0], aw_ok[0]);
         end
         tick();
      end
      bus_awr = 1;
      @(negedge clk);
      tests++;
      if (aw_sel[0] !== 2'd2) begin
         fails++;
         $display("FAIL lock_hs got %0d want 2", aw_sel[0]);
      end
      tick();
      @(negedge clk);
      tests++;
      if (aw_sel[0] !== 2'd0 || w_ok[0] !== 1'b1 || w_sel[0] !== 2'd2) begin
         fails++;
         $display("FAIL lock_next got aw=%0d w=%0d/%0b want aw=0 w=2/1",
                  aw_sel[0], w_sel[0], w_ok[0]);
      end
      tick();
   endtask

   task automatic test_decoupled_w();
      do_reset();
      bus_awv = 1; bus_awr = 1;
      awv = 4'b0010;
      @(negedge clk);
      tests++;
      if (w_ok[0] !== 1'b0 || aw_sel[0] !== 2'd1) begin
         fails++;
         $display("FAIL w_pre got w_ok=%0b aw=%0d want 0/1", w_ok[0], aw_sel[0]);
      end
      tick();
      awv = 4'b1000;
      @(negedge clk);
      tests++;
      if (w_ok[0] !== 1'b1 || w_sel[0] !== 2'd1 || aw_sel[0] !== 2'd3) begin
         fails++;
         $display("FAIL w_lat got w=%0d/%0b aw=%0d want w=1/1 aw=3",
                  w_sel[0], w_ok[0], aw_sel[0]);
      end
      tick();
      awv = 4'b0001;
      tick();
      awv = 4'b0000; bus_awv = 0;
      bus_wv = 1; bus_wr = 1; bus_wl = 0;
      tick();
      bus_wl = 1;
      @(negedge clk);
      tests++;
      if (w_sel[0] !== 2'd1 || w_ok[0] !== 1'b1) begin
         fails++;
         $display("FAIL w_nonlast got %0d/%0b want 1/1", w_sel[0], w_ok[0]);
      end
      tick();
      @(negedge clk);
      tests++;
      if (w_sel[0] !== 2'd3 || w_ok[0] !== 1'b1) begin
         fails++;
         $display("FAIL w_pop1 got %0d/%0b want 3/1", w_sel[0], w_ok[0]);
      end
      tick();
      @(negedge clk);
      tests++;
      if (w_sel[0] !== 2'd0 || w_ok[0] !== 1'b1) begin
         fails++;
         $display("FAIL w_pop2 got %0d/%0b want 0/1", w_sel[0], w_ok[0]);
      end
      tick();
      bus_wv = 0;
      @(negedge clk);
      tests++;
      if (w_ok[0] !== 1'b0) begin
         fails++;
         $display("FAIL w_empty got %0b want 0", w_ok[0]);
      end
      tick();
   endtask

   task automatic test_fifo_full();
      do_reset();
      awv = 4'b0001;
      bus_awv = 1; bus_awr = 1;
      for (int k = 0; k < 4; k++) begin
         @(negedge clk);
         tests++;
         if (aw_ok[0] !== 1'b1) begin
            fails++;
            $display("FAIL full_fill k=%0d got %0b want 1", k, aw_ok[0]);
         end
         tick();
      end
      @(negedge clk);
      tests++;
      if (aw_ok[0] !== 1'b0) begin
         fails++;
         $display("FAIL full_block got %0b want 0", aw_ok[0]);
      end
      tick();
      bus_wv = 1; bus_wr = 1; bus_wl = 1;
      @(negedge clk);
      tests++;
      if (aw_ok[0] !== 1'b0) begin
         fails++;
         $display("FAIL full_popcycle got %0b want 0", aw_ok[0]);
      end
      tick();
      bus_wv = 0;
      @(negedge clk);
      tests++;
      if (aw_ok[0] !== 1'b1) begin
         fails++;
         $display("FAIL full_release got %0b want 1", aw_ok[0]);
      end
      tick();
      @(negedge clk);
      tests++;
      if (aw_ok[0] !== 1'b0) begin
         fails++;
         $display("FAIL full_refill got %0b want 0", aw_ok[0]);
      end
      tick();
   endtask

   task automatic test_routing_reset();
      do_reset();
      bid = 4'b1001; rid = 4'b0111;
      #1;
      tests++;
      if (b_sel[0] !== 2'd2 || r_sel[0] !== 2'd1) begin
         fails++;
         $display("FAIL route1 got b=%0d r=%0d want b=2 r=1", b_sel[0], r_sel[0]);
      end
      bid = 4'b1110; rid = 4'b1000;
      #1;
      tests++;
      if (b_sel[0] !== 2'd3 || r_sel[0] !== 2'd2) begin
         fails++;
         $display("FAIL route2 got b=%0d r=%0d want b=3 r=2", b_sel[0], r_sel[0]);
      end
      tick();
      bus_wv = 1; bus_wr = 1; bus_wl = 0;
      awv = 4'b0010; bus_awv = 1; bus_awr = 1;
      arv = 4'b0100; bus_arv = 1; bus_arr = 0;
      tick();
      awv = 4'b0100; bus_awr = 0;
      tick();
      @(negedge clk);
      tests++;
      if (w_sel[0] !== 2'd1 || w_ok[0] !== 1'b1 || aw_sel[0] !== 2'd2) begin
         fails++;
         $display("FAIL rst_pre got w=%0d/%0b aw=%0d want w=1/1 aw=2",
                  w_sel[0], w_ok[0], aw_sel[0]);
      end
      @(posedge clk);
      #2 rst = 1'b1;
      #1;
      tests++;
      if ({w_sel[0], w_ok[0], aw_sel[0], aw_ok[0], ar_sel[0], ar_ok[0]}
          !== 9'b0) begin
         fails++;
         $display("FAIL rst_mid got w=%0d/%0b aw=%0d/%0b ar=%0d/%0b want all 0",
                  w_sel[0], w_ok[0], aw_sel[0], aw_ok[0], ar_sel[0], ar_ok[0]);
      end
      awv = '0; arv = '0;
      tick();
      rst = 1'b0;
      @(negedge clk);
      tests++;
      if (aw_ok[0] !== 1'b0 || w_ok[0] !== 1'b0 || ar_ok[0] !== 1'b0) begin
         fails++;
         $display("FAIL rst_after got aw=%0b w=%0b ar=%0b want 0",
                  aw_ok[0], w_ok[0], ar_ok[0]);
      end
      tick();
      awv = 4'b1000;
      @(negedge clk);
      tests++;
      if (aw_sel[0] !== 2'd3 || aw_ok[0] !== 1'b1) begin
         fails++;
         $display("FAIL rst_newreq got %0d/%0b want 3/1", aw_sel[0], aw_ok[0]);
      end
      tick();
   endtask

   initial begin
      test_reset();
      test_rr_fairness();
      test_ar_rr_lock();
      test_fixed_priority();
      test_lock();
      test_decoupled_w();
      test_fifo_full();
      test_routing_reset();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
